lsb_stream_decoder: RTL and testbench



---
 rtl/lsb_stream_decoder.sv | 186 ++++++++++++++++++
 tb/tb_lsb_stream_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_stream_decoder.sv
// lsb_stream_decoder: strips LSB_BITS from each carrier sample, assembles a
// big-endian length header of LEN_BYTES bytes, then emits exactly the declared
// number of payload bytes through a single-entry valid/ready output register.
module lsb_stream_decoder #(
  parameter int DATA_W      = 8,
  parameter int LSB_BITS    = 2,
  parameter int LEN_BYTES   = 3,
  parameter int LEN_IN_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*LEN_BYTES-1:0] len_out,
  output logic                   len_valid,
  output logic                   busy,
  output logic                   done
);

  // Carriers per recovered byte and the derived counter widths.
  localparam int K     = 8 / LSB_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int HDR_W = $clog2(LEN_BYTES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(LEN_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [HDR_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               len_valid_q, len_valid_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               out_stall_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               byte_done_s;
  logic [8+LSB_BITS-1:0] acc_wide_s;
  logic [7:0]         acc_shift_s;
  logic [LEN_W+7:0]   len_wide_s;
  logic [LEN_W-1:0]   len_shift_s;
  logic [LEN_W-1:0]   hdr_bytes_s;
  logic               unused_in_bits_s;

  // Upper carrier bits carry no hidden data; fold them so they are visibly consumed.
  assign unused_in_bits_s = ^in_data;

  // The output register blocks new carriers only while it holds an undrained byte.
  // Once every payload byte has been recovered no further carriers are taken.
  assign out_stall_s = out_valid_q && !out_ready;
  assign in_ready_s  = ((state_q == ST_HEADER) ||
                        ((state_q == ST_PAYLOAD) && (rem_q != '0))) && !out_stall_s;
  assign accept_s    = in_valid && in_ready_s;
  assign byte_done_s = accept_s && (cnt_q == CNT_LAST);

  // Shift the new LSBs into the accumulator; the first carrier ends up in the MSBs.
  assign acc_wide_s  = {acc_q, in_data[LSB_BITS-1:0]};
  assign acc_shift_s = acc_wide_s[7:0];

  // Header bytes shift in from the LSB end, so the first byte becomes the MSB byte.
  assign len_wide_s  = {len_q, acc_shift_s};
  assign len_shift_s = len_wide_s[LEN_W-1:0];
  assign hdr_bytes_s = (LEN_IN_BITS != 0) ? (len_shift_s >> 3) : len_shift_s;

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    hdr_cnt_d   = hdr_cnt_q;
    len_d       = len_q;
    len_valid_d = len_valid_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (accept_s) begin
      acc_d = acc_shift_s;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNT_W'(1));
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_HEADER;
          cnt_d       = '0;
          acc_d       = '0;
          hdr_cnt_d   = '0;
          len_d       = '0;
          len_valid_d = 1'b0;
          rem_d       = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_HEADER: begin
        if (byte_done_s) begin
          len_d = len_shift_s;
          if (hdr_cnt_q == HDR_LAST) begin
            len_valid_d = 1'b1;
            rem_d       = hdr_bytes_s;
            hdr_cnt_d   = '0;
            state_d     = (hdr_bytes_s == '0) ? ST_DONE : ST_PAYLOAD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
          end
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (byte_done_s) begin
          // A byte can only complete while the register is free or draining.
          out_data_d  = acc_shift_s;
          out_valid_d = 1'b1;
          rem_d       = rem_q - LEN_W'(1);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      hdr_cnt_q   <= '0;
      len_q       <= '0;
      len_valid_q <= 1'b0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      len_valid_q <= len_valid_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign len_out   = len_q;
  assign len_valid = len_valid_q;
  assign busy      = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lsb_stream_decoder.sv
// Scoreboard bench for lsb_stream_decoder: a 2-bit/3-byte/bit-length instance
// under random traffic and directed corner cases, plus a 1-bit/2-byte/byte-length instance.
module tb_lsb_stream_decoder;

  localparam int K = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals (LSB_BITS=2, LEN_BYTES=3, LEN_IN_BITS=1)
  logic        rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid, len_valid, busy, done;
  logic [7:0]  out_data;
  logic [23:0] len_out;

  // Instance B signals (LSB_BITS=1, LEN_BYTES=2, LEN_IN_BITS=0)
  logic        b_rst = 1'b1, b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [7:0]  b_in_data = 8'h00;
  logic        b_in_ready, b_out_valid, b_len_valid, b_busy, b_done;
  logic [7:0]  b_out_data;
  logic [15:0] b_len_out;

  lsb_stream_decoder #(.DATA_W(8), .LSB_BITS(2), .LEN_BYTES(3), .LEN_IN_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .len_out(len_out), .len_valid(len_valid), .busy(busy), .done(done));

  lsb_stream_decoder #(.DATA_W(8), .LSB_BITS(1), .LEN_BYTES(2), .LEN_IN_BITS(0)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .len_out(b_len_out), .len_valid(b_len_valid), .busy(b_busy), .done(b_done));

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] car_q[$];
  logic [7:0] pay_q[$];

  int bp_mode  = 0;
  int hold_cnt = 0;
  int arm_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (arm_hold != 0 && out_valid) begin
      hold_cnt = 5;
      arm_hold = 0;
    end
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else if (bp_mode != 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  endtask

  // Reference packing: a byte is split MSB-first into K two-bit carriers, junk above.
  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < K; i++)
      car_q.push_back({6'($urandom), 2'((b >> (6 - 2 * i)) & 8'h03)});
  endtask

  // Build header and npay payload bytes; the expected output is queued here.
  task automatic build(input logic [23:0] len, input int npay, input bit push);
    logic [7:0] b;
    add_byte(len[23:16]);
    add_byte(len[15:8]);
    add_byte(len[7:0]);
    for (int j = 0; j < npay; j++) begin
      b = (j < pay_q.size()) ? pay_q[j] : 8'($urandom);
      add_byte(b);
      if (push) exp_q.push_back(b);
    end
    pay_q.delete();
  endtask

  // Present each queued carrier until it is accepted; optional stray start pulse.
  task automatic feed(input int glitch_at);
    int  t;
    bit  ok;
    for (int i = 0; i < car_q.size(); i++) begin
      if (bp_mode != 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_data  = car_q[i];
      in_valid = 1'b1;
      start    = (i == glitch_at);
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = in_ready;
        tick();
        t++;
      end
      start = 1'b0;
      if (!ok) begin
        checks++;
        $display("FAIL feed_timeout: carrier %0d not accepted within %0d cycles", i, t);
        break;
      end
    end
    in_valid = 1'b0;
    car_q.delete();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 400) begin
      tick();
      t++;
    end
    check("done", done, 1);
  endtask

  // One complete frame with end-of-frame checks.
  task automatic frame(input logic [23:0] len, input int glitch_at);
    int n;
    bit was_done;
    n = int'(len >> 3);
    build(len, n, 1'b1);
    was_done = done;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (was_done) begin
      check("restart_done_low", done, 0);
      check("restart_busy", busy, 1);
      check("restart_len_valid_low", len_valid, 0);
    end
    feed(glitch_at);
    if (n == 0) check("zero_len_done_latency", done, 1);
    wait_done();
    check("len_out", len_out, len);
    check("len_valid", len_valid, 1);
    check("out_valid_in_done", out_valid, 0);
    check("exp_drained", exp_q.size(), 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    check("in_ready_in_done", in_ready, 0);
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor for instance A: compares every handshaken byte and stall behaviour.
  bit         held = 1'b0;
  logic [7:0] held_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        held      = 1'b1;
        held_data = out_data;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got %0h expected no byte", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        $display("FAIL b_out_unexpected: got %0h expected no byte", b_out_data);
      end else begin
        check("b_out_data", b_out_data, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bseq[$];
    logic [23:0] rlen;
    int t;
    bit ok;

    rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    rst = 1'b0; b_rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_len_valid", len_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_out", len_out, 0);
    check("rst_out_data", out_data, 0);

    // Directed frame: len = 16 bits -> 0xA5, 0xC2.
    pay_q.push_back(8'hA5); pay_q.push_back(8'hC2);
    frame(24'h000010, -1);

    // Same frame with 5 cycles of backpressure after the first byte.
    arm_hold = 1;
    pay_q.push_back(8'hA5); pay_q.push_back(8'hC2);
    frame(24'h000010, -1);

    // Zero length header goes straight to DONE.
    frame(24'h000000, -1);

    // Remainder bits ignored: 15 bits -> one byte.
    frame(24'h00000F, -1);

    // Stray start during HEADER is ignored.
    frame(24'h000018, 3);

    // Reset in the middle of PAYLOAD with a byte waiting.
    hold_cnt = 1000;
    build(24'h000100, 1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    feed(-1);
    check("pre_reset_out_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_cnt = 0;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_len_valid", len_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_len_out", len_out, 0);
    frame(24'h000020, -1);

    // Random frames under random backpressure and input gaps.
    bp_mode = 1;
    for (int f = 0; f < 8; f++) begin
      rlen = 24'($urandom_range(0, 80));
      frame(rlen, -1);
    end
    bp_mode = 0;

    // Instance B: len = 0x0001 bytes, payload bits 1,0,1,1,0,0,1,0 -> 0xB2.
    bseq.push_back(8'h00); bseq.push_back(8'h01); bseq.push_back(8'hB2);
    exp_b_q.push_back(8'hB2);
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b_in_data  = {7'($urandom), bseq[i / 8][7 - (i % 8)]};
      b_in_valid = 1'b1;
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = b_in_ready;
        tick();
        t++;
      end
      if (!ok) begin
        checks++;
        $display("FAIL b_feed_timeout: carrier %0d not accepted", i);
        break;
      end
    end
    b_in_valid = 1'b0;
    t = 0;
    while (!b_done && t < 50) begin
      tick();
      t++;
    end
    check("b_done", b_done, 1);
    check("b_len_out", b_len_out, 16'h0001);
    check("b_len_valid", b_len_valid, 1);
    check("b_exp_drained", exp_b_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
